bridge_cmd_engine: RTL and testbench

Parametrised host/core command engine on the APF bridge bus. It decodes the host and core command register windows and executes host→core commands ("CM"), presenting them on a valid/done port. It arbitrates up to NUM_REQ core→host requesters ("cm") round-robin and adds a per-request timeout. Parameter/response width is configurable from 1 to 8 words, with byte-order handling of the data words. It replaces the fixed single-requester 4-word command driver in the bridge clock domain.

---
 rtl/bridge_cmd_pkg.sv | 41 ++++
 rtl/bridge_cmd_rr_arbiter.sv | 43 ++++
 rtl/bridge_cmd_engine.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_bridge_cmd_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_cmd_pkg.sv
// Shared types and constants for the bridge command engine.
// Holds the FSM state encodings, the ASCII tags, the window offsets and the byte-order helper.
package bridge_cmd_pkg;

    typedef enum logic [1:0] {
        HostIdle,
        HostValid,
        HostDone
    } host_state_e;

    typedef enum logic [1:0] {
        ReqIdle,
        ReqPosted,
        ReqWait,
        ReqDone
    } req_state_e;

    // Upper-case tags belong to host commands, lower-case tags to core requests.
    localparam logic [15:0] AsciiCM   = 16'h434D;
    localparam logic [15:0] AsciiBU   = 16'h4255;
    localparam logic [15:0] AsciiOK   = 16'h4F4B;
    localparam logic [15:0] AsciiER   = 16'h4552;
    localparam logic [15:0] AsciiCmLc = 16'h636D;
    localparam logic [15:0] AsciiBuLc = 16'h6275;
    localparam logic [15:0] AsciiOkLc = 16'h6F6B;

    localparam logic [26:0] OffCmd   = 27'h000;
    localparam logic [26:0] OffInfo0 = 27'h004;
    localparam logic [26:0] OffInfo1 = 27'h008;
    localparam logic [26:0] OffParam = 27'h020;
    localparam logic [26:0] OffResp  = 27'h040;

    localparam logic [31:0] InfoVal0    = 32'h0000_0020;
    localparam logic [31:0] InfoVal1    = 32'h0000_0040;
    localparam logic [31:0] UnmappedVal = 32'hFFFF_FFFF;

    function automatic logic [31:0] to_be(input logic little, input logic [31:0] word);
        return little ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;
    endfunction

endpackage

// File: rtl/bridge_cmd_rr_arbiter.sv
// Round-robin arbiter over the core request channels.
// The search starts one past the last committed grant; the pointer moves only on commit.
module bridge_cmd_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               commit_i,
    input  logic [IDX_W-1:0]   commit_idx_i,
    output logic               gnt_valid_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic [IDX_W-1:0] last_q;
    int unsigned      cand;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (commit_i) begin
            last_q <= commit_idx_i;
        end
    end

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_q) + k) % NUM_REQ;
            if (!gnt_valid_o && req_i[IDX_W'(cand)]) begin
                gnt_valid_o           = 1'b1;
                gnt_o[IDX_W'(cand)]   = 1'b1;
                gnt_idx_o             = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bridge_cmd_engine.sv
// Host/core command engine on the bridge bus: decodes both command windows, runs host
// commands out on cmd_*, and serves core requesters round-robin with a per-request timeout.
module bridge_cmd_engine
    import bridge_cmd_pkg::*;
#(
    parameter logic [31:0] HOST_BASE      = 32'hF800_0000,
    parameter logic [31:0] CORE_BASE      = 32'hF800_1000,
    parameter int unsigned PARAM_WORDS    = 4,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     bridge_addr,
    input  logic                            bridge_rd,
    input  logic                            bridge_wr,
    input  logic [31:0]                     bridge_wr_data,
    output logic [31:0]                     bridge_rd_data,
    input  logic                            bridge_endian_little,
    output logic                            cmd_valid,
    output logic [15:0]                     cmd_word,
    output logic [32*PARAM_WORDS-1:0]       cmd_param,
    input  logic [15:0]                     cmd_progress,
    input  logic                            cmd_done,
    input  logic [15:0]                     cmd_result,
    input  logic [32*PARAM_WORDS-1:0]       cmd_response,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [16*NUM_REQ-1:0]           req_word,
    input  logic [32*PARAM_WORDS*NUM_REQ-1:0] req_param,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [15:0]                     req_progress,
    output logic [15:0]                     req_result,
    output logic [32*PARAM_WORDS-1:0]       req_response,
    output logic                            req_timeout
);

    localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    // Address decode
    logic [26:0]            host_off, core_off;
    logic                   host_cmd_we, core_sts_we;
    logic [PARAM_WORDS-1:0] host_param_we, core_resp_we;
    logic [31:0]            rd_mux, rd_data_q;
    logic                   unused_addr;

    assign host_off    = bridge_addr[26:0] - HOST_BASE[26:0];
    assign core_off    = bridge_addr[26:0] - CORE_BASE[26:0];
    assign unused_addr = ^bridge_addr[31:27];

    // Host side state
    host_state_e             host_state_q, host_state_d;
    logic [31:0]             host_status_q, host_status_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    host_latch, host_resp_latch;
    logic [15:0]             cmd_word_q;
    logic [32*PARAM_WORDS-1:0] cmd_param_q;
    logic [31:0]             host_param_q [PARAM_WORDS];
    logic [31:0]             host_resp_q  [PARAM_WORDS];

    // Core request side state
    req_state_e              req_state_q, req_state_d;
    logic [IdxW-1:0]         gnt_idx_q, gnt_idx;
    logic [NUM_REQ-1:0]      gnt_onehot;
    logic                    gnt_valid;
    logic                    req_accept, req_to, req_ok, req_bu, core_cmd_clr, timer_hit;
    logic [31:0]             core_cmd_q, core_status_q;
    logic [31:0]             req_param_q [PARAM_WORDS];
    logic [31:0]             core_resp_q [PARAM_WORDS];
    logic [TimerW-1:0]       timer_q, timer_d;
    logic [NUM_REQ-1:0]      req_ready_q;
    logic [15:0]             req_progress_q, req_result_q;
    logic [32*PARAM_WORDS-1:0] req_response_q;
    logic                    req_timeout_q;

    always_comb begin
        host_cmd_we = bridge_wr && (host_off == OffCmd);
        core_sts_we = bridge_wr && (core_off == OffCmd);
        for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
            host_param_we[i] = bridge_wr && (host_off == OffParam + 27'(4 * i));
            core_resp_we[i]  = bridge_wr && (core_off == OffResp + 27'(4 * i));
        end
    end

    always_comb begin
        rd_mux = UnmappedVal;
        if (host_off == OffInfo0 || core_off == OffInfo0) rd_mux = InfoVal0;
        if (host_off == OffInfo1 || core_off == OffInfo1) rd_mux = InfoVal1;
        if (host_off == OffCmd) rd_mux = host_status_q;
        if (core_off == OffCmd) rd_mux = core_cmd_q;
        for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
            if (host_off == OffResp + 27'(4 * i)) begin
                rd_mux = to_be(bridge_endian_little, host_resp_q[i]);
            end
            if (core_off == OffParam + 27'(4 * i)) begin
                rd_mux = to_be(bridge_endian_little, req_param_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (bridge_rd) begin
            rd_data_q <= rd_mux;
        end
    end

    // Host command FSM
    always_comb begin
        host_state_d    = host_state_q;
        host_status_d   = host_status_q;
        host_latch      = 1'b0;
        host_resp_latch = 1'b0;
        unique case (host_state_q)
            HostIdle: begin
                if (host_cmd_we) begin
                    if (bridge_wr_data[31:16] == AsciiCM) begin
                        host_state_d  = HostValid;
                        host_status_d = {AsciiBU, 16'h0000};
                        host_latch    = 1'b1;
                    end else begin
                        host_status_d = {AsciiER, 16'h0001};
                    end
                end
            end
            HostValid: begin
                if (cmd_done) begin
                    host_state_d    = HostDone;
                    host_status_d   = {AsciiOK, cmd_result};
                    host_resp_latch = 1'b1;
                end else begin
                    host_status_d = {AsciiBU, cmd_progress};
                end
            end
            HostDone: host_state_d = HostIdle;
            default:  host_state_d = HostIdle;
        endcase
        // Registered one cycle behind the state so valid lands two cycles after the write.
        cmd_valid_d = (host_state_q == HostValid) && (host_state_d == HostValid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            host_state_q  <= HostIdle;
            host_status_q <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_word_q    <= '0;
            cmd_param_q   <= '0;
            for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
                host_param_q[i] <= '0;
                host_resp_q[i]  <= '0;
            end
        end else begin
            host_state_q  <= host_state_d;
            host_status_q <= host_status_d;
            cmd_valid_q   <= cmd_valid_d;
            for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
                if (host_param_we[i]) begin
                    host_param_q[i] <= to_be(bridge_endian_little, bridge_wr_data);
                end
                if (host_latch) cmd_param_q[32*i +: 32] <= host_param_q[i];
                if (host_resp_latch) host_resp_q[i] <= cmd_response[32*i +: 32];
            end
            if (host_latch) cmd_word_q <= bridge_wr_data[15:0];
        end
    end

    // Core request FSM
    bridge_cmd_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IdxW)
    ) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid),
        .commit_i    (req_state_q == ReqDone),
        .commit_idx_i(gnt_idx_q),
        .gnt_valid_o (gnt_valid),
        .gnt_o       (gnt_onehot),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        req_state_d  = req_state_q;
        req_accept   = 1'b0;
        req_to       = 1'b0;
        req_ok       = 1'b0;
        req_bu       = 1'b0;
        timer_hit    = (timer_q == TimerLast);
        timer_d      = timer_q;
        unique case (req_state_q)
            ReqIdle: begin
                if (gnt_valid) begin
                    req_state_d = ReqPosted;
                    req_accept  = 1'b1;
                end
            end
            ReqPosted: begin
                if (timer_hit) begin
                    req_state_d = ReqDone;
                    req_to      = 1'b1;
                end else if (core_sts_we) begin
                    req_state_d = ReqWait;
                end
            end
            ReqWait: begin
                if (timer_hit) begin
                    req_state_d = ReqDone;
                    req_to      = 1'b1;
                end else if (core_status_q[31:16] == AsciiOkLc) begin
                    req_state_d = ReqDone;
                    req_ok      = 1'b1;
                end else if (core_status_q[31:16] == AsciiBuLc) begin
                    req_bu = 1'b1;
                end
            end
            ReqDone: req_state_d = ReqIdle;
            default: req_state_d = ReqIdle;
        endcase
        if ((req_state_q == ReqPosted || req_state_q == ReqWait) && timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
        core_cmd_clr = req_to || (req_state_q == ReqPosted && core_sts_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_state_q    <= ReqIdle;
            gnt_idx_q      <= '0;
            core_cmd_q     <= '0;
            core_status_q  <= '0;
            timer_q        <= '0;
            req_ready_q    <= '0;
            req_progress_q <= '0;
            req_result_q   <= '0;
            req_response_q <= '0;
            req_timeout_q  <= 1'b0;
            for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
                req_param_q[i] <= '0;
                core_resp_q[i] <= '0;
            end
        end else begin
            req_state_q <= req_state_d;
            req_ready_q <= req_accept ? gnt_onehot : '0;
            for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
                if (core_resp_we[i]) begin
                    core_resp_q[i] <= to_be(bridge_endian_little, bridge_wr_data);
                end
            end
            // Clearing status at accept keeps a stale "ok" from completing the new request.
            if (req_accept) begin
                gnt_idx_q     <= gnt_idx;
                core_cmd_q    <= {AsciiCmLc, req_word[16*gnt_idx +: 16]};
                core_status_q <= '0;
                timer_q       <= '0;
                req_timeout_q <= 1'b0;
                for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
                    req_param_q[i] <= req_param[32*(PARAM_WORDS*32'(gnt_idx) + i) +: 32];
                end
            end else begin
                timer_q <= timer_d;
                if (core_sts_we) core_status_q <= bridge_wr_data;
                if (core_cmd_clr) core_cmd_q <= '0;
            end
            if (req_to) req_timeout_q <= 1'b1;
            if (req_bu) req_progress_q <= core_status_q[15:0];
            if (req_ok) begin
                req_result_q <= core_status_q[15:0];
                for (int unsigned i = 0; i < PARAM_WORDS; i++) begin
                    req_response_q[32*i +: 32] <= core_resp_q[i];
                end
            end
        end
    end

    assign bridge_rd_data = rd_data_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_word       = cmd_word_q;
    assign cmd_param      = cmd_param_q;
    assign req_ready      = req_ready_q;
    assign req_done       = (req_state_q == ReqDone) ? (NUM_REQ'(1) << gnt_idx_q) : '0;
    assign req_progress   = req_progress_q;
    assign req_result     = req_result_q;
    assign req_response   = req_response_q;
    assign req_timeout    = req_timeout_q;

endmodule

// File: tb/tb_bridge_cmd_engine.sv
// Directed bench for bridge_cmd_engine with a short timeout so expiry is reachable.
module tb_bridge_cmd_engine;

    localparam int unsigned PW = 4;
    localparam int unsigned NR = 2;
    localparam logic [31:0] H  = 32'hF800_0000;
    localparam logic [31:0] C  = 32'hF800_1000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [31:0]          bridge_addr, bridge_wr_data, bridge_rd_data;
    logic                 bridge_rd, bridge_wr, bridge_endian_little;
    logic                 cmd_valid, cmd_done;
    logic [15:0]          cmd_word, cmd_progress, cmd_result;
    logic [32*PW-1:0]     cmd_param, cmd_response;
    logic [NR-1:0]        req_valid, req_ready, req_done;
    logic [16*NR-1:0]     req_word;
    logic [32*PW*NR-1:0]  req_param;
    logic [15:0]          req_progress, req_result;
    logic [32*PW-1:0]     req_response;
    logic                 req_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bridge_cmd_engine #(
        .HOST_BASE     (H),
        .CORE_BASE     (C),
        .PARAM_WORDS   (PW),
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .bridge_addr         (bridge_addr),
        .bridge_rd           (bridge_rd),
        .bridge_wr           (bridge_wr),
        .bridge_wr_data      (bridge_wr_data),
        .bridge_rd_data      (bridge_rd_data),
        .bridge_endian_little(bridge_endian_little),
        .cmd_valid           (cmd_valid),
        .cmd_word            (cmd_word),
        .cmd_param           (cmd_param),
        .cmd_progress        (cmd_progress),
        .cmd_done            (cmd_done),
        .cmd_result          (cmd_result),
        .cmd_response        (cmd_response),
        .req_valid           (req_valid),
        .req_word            (req_word),
        .req_param           (req_param),
        .req_ready           (req_ready),
        .req_done            (req_done),
        .req_progress        (req_progress),
        .req_result          (req_result),
        .req_response        (req_response),
        .req_timeout         (req_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bridge_addr    = a;
        bridge_wr_data = d;
        bridge_wr      = 1'b1;
        tick();
        bridge_wr      = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bridge_addr = a;
        bridge_rd   = 1'b1;
        tick();
        bridge_rd   = 1'b0;
        check(tag, bridge_rd_data, exp);
    endtask

    initial begin
        reset = 1'b1;
        bridge_addr = '0; bridge_wr_data = '0; bridge_rd = 1'b0; bridge_wr = 1'b0;
        bridge_endian_little = 1'b0;
        cmd_progress = '0; cmd_done = 1'b0; cmd_result = '0; cmd_response = '0;
        req_valid = '0; req_word = '0; req_param = '0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_req_done", 32'(req_done), 32'h0);
        check("rst_req_timeout", 32'(req_timeout), 32'h0);
        check("rst_rd_data", bridge_rd_data, 32'h0);
        reset = 1'b0;
        tick();
        read_check("rst_host_status", H, 32'h0);
        read_check("info0", H + 32'h4, 32'h20);
        read_check("info1", C + 32'h8, 32'h40);
        read_check("unmapped", H + 32'h100, 32'hFFFF_FFFF);
        read_check("rst_core_cmd", C, 32'h0);

        // Host command, big-endian
        cmd_response = {96'h0, 32'hCAFE_F00D};
        bus_write(H + 32'h20, 32'h1122_3344);
        bus_write(H, 32'h434D_0005);
        check("cm_valid_1cyc", 32'(cmd_valid), 32'h0);
        check("cm_word", 32'(cmd_word), 32'h5);
        tick();
        check("cm_valid_2cyc", 32'(cmd_valid), 32'h1);
        check("cm_param0", cmd_param[31:0], 32'h1122_3344);
        cmd_progress = 16'h0003;
        tick();
        read_check("cm_busy", H, 32'h4255_0003);
        cmd_done = 1'b1; cmd_result = 16'h0007;
        tick();
        cmd_done = 1'b0;
        check("cm_valid_drop", 32'(cmd_valid), 32'h0);
        read_check("cm_ok", H, 32'h4F4B_0007);
        read_check("cm_resp0", H + 32'h40, 32'hCAFE_F00D);

        // Host command, little-endian data words
        bridge_endian_little = 1'b1;
        bus_write(H + 32'h20, 32'h1122_3344);
        bus_write(H, 32'h434D_0006);
        check("le_word", 32'(cmd_word), 32'h6);
        check("le_param0", cmd_param[31:0], 32'h4433_2211);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        read_check("le_resp0", H + 32'h40, 32'h0DF0_FECA);
        bridge_endian_little = 1'b0;

        // Core requests: both channels held, grant order 0,1,0,1
        req_word = {16'h00B1, 16'h00A0};
        req_param[31:0] = 32'h0A0B_0C0D;
        req_param[128 +: 32] = 32'h0102_0304;
        req_valid = 2'b11;
        tick();
        check("g0_ready", 32'(req_ready), 32'h1);
        read_check("g0_core_cmd", C, 32'h636D_00A0);
        read_check("g0_param0", C + 32'h20, 32'h0A0B_0C0D);
        bus_write(C + 32'h40, 32'h1234_5678);
        bus_write(C, 32'h6F6B_0009);
        check("g0_done_early", 32'(req_done), 32'h0);
        tick();
        check("g0_done", 32'(req_done), 32'h1);
        check("g0_result", 32'(req_result), 32'h9);
        check("g0_resp0", req_response[31:0], 32'h1234_5678);
        check("g0_timeout", 32'(req_timeout), 32'h0);
        tick();
        check("g1_done_idle", 32'(req_done), 32'h0);
        tick();
        check("g1_ready", 32'(req_ready), 32'h2);
        read_check("g1_core_cmd", C, 32'h636D_00B1);
        bus_write(C, 32'h6275_0004);
        tick();
        tick();
        check("g1_stale_no_done", 32'(req_done), 32'h0);
        check("g1_progress", 32'(req_progress), 32'h4);
        bridge_endian_little = 1'b1;
        bus_write(C + 32'h40, 32'hAABB_CCDD);
        bus_write(C, 32'h6F6B_0011);
        bridge_endian_little = 1'b0;
        tick();
        check("g1_done", 32'(req_done), 32'h2);
        check("g1_result", 32'(req_result), 32'h11);
        check("g1_resp0_le", req_response[31:0], 32'hDDCC_BBAA);
        tick();
        tick();
        check("g2_ready", 32'(req_ready), 32'h1);
        bus_write(C, 32'h6F6B_0001);
        tick();
        check("g2_done", 32'(req_done), 32'h1);
        tick();
        tick();
        check("g3_ready", 32'(req_ready), 32'h2);
        req_valid = 2'b00;

        // Timeout with no core status write
        repeat (15) tick();
        check("to_not_yet", 32'(req_done), 32'h0);
        tick();
        check("to_done", 32'(req_done), 32'h2);
        check("to_flag", 32'(req_timeout), 32'h1);
        read_check("to_core_cmd", C, 32'h0);
        check("to_flag_held", 32'(req_timeout), 32'h1);

        // Core status write in the timeout cycle loses to the timeout
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("race_ready", 32'(req_ready), 32'h1);
        check("race_timeout_clr", 32'(req_timeout), 32'h0);
        repeat (15) tick();
        bus_write(C, 32'h6F6B_0005);
        check("race_done", 32'(req_done), 32'h1);
        check("race_timeout", 32'(req_timeout), 32'h1);
        check("race_result", 32'(req_result), 32'h1);
        tick();

        // Reset in host VALID aborts the command
        bus_write(H, 32'h434D_0001);
        tick();
        check("ab_valid", 32'(cmd_valid), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ab_valid_clr", 32'(cmd_valid), 32'h0);
        check("ab_word_clr", 32'(cmd_word), 32'h0);
        check("ab_no_done", 32'(req_done), 32'h0);
        read_check("ab_status", H, 32'h0);
        bus_write(H, 32'h1234_0000);
        read_check("err_status", H, 32'h4552_0001);
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        check("rst_first_grant", 32'(req_ready), 32'h1);
        check("rst_timeout_clr", 32'(req_timeout), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
